// File: rtl/mac_result_collector.sv
// Accumulates groups of MAC partial sums into long-vector dot products and
// buffers finished results in a small FWFT FIFO behind a valid/ready port.
module mac_result_collector #(
  parameter int SUM_W = 20,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [SUM_W-1:0]           in_sum,
  input  logic [CNT_W-1:0]           cfg_len,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_acc,
  output logic                       out_sat,
  output logic                       grp_busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [CNT_W:0] LEN_MAX = {1'b1, {CNT_W{1'b0}}};

  typedef struct packed {
    logic             sat;
    logic [ACC_W-1:0] acc;
  } result_t;

  // Group accumulator state
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   len_r;
  logic             sat_r;

  // FIFO state
  result_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  // Datapath
  logic             grp_start;
  logic [CNT_W:0]   eff_len;
  logic [ACC_W:0]   sum;
  result_t          res;
  logic             last;
  logic             beat;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;

  // NOTE: every signal driven here gets a default first so no latch is
  // inferred, and combinational logic uses blocking assignments only.
  always_comb begin
    grp_start = (cnt == '0);
    eff_len   = len_r;
    if (grp_start)
      eff_len = (cfg_len == '0) ? LEN_MAX : {1'b0, cfg_len};

    sum     = {1'b0, (grp_start ? {ACC_W{1'b0}} : acc)}
            + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
    res.acc = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    res.sat = sum[ACC_W] || (!grp_start && sat_r);

    last  = (({1'b0, cnt} + (CNT_W + 1)'(1)) == eff_len);
    beat  = in_valid && !clear;
    push  = beat && last;
    pop   = (count != '0) && out_ready;
    full  = (count == LVL_W'(DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en = push && (!full || pop);
    drop  = push && full && !pop;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      len_r <= '0;
      sat_r <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      cnt   <= '0;
      sat_r <= 1'b0;
    end else if (in_valid) begin
      if (grp_start)
        len_r <= eff_len;
      if (last) begin
        acc   <= '0;
        cnt   <= '0;
        sat_r <= 1'b0;
      end else begin
        acc   <= res.acc;
        sat_r <= res.sat;
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_drop <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !pop)
        count <= count + LVL_W'(1);
      else if (pop && !wr_en)
        count <= count - LVL_W'(1);
      if (drop)
        err_drop <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entries are only observed
  // through out_valid, which the pointer/count reset already covers.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= res;
  end

  assign out_valid  = (count != '0);
  assign out_acc    = out_valid ? mem[rd_ptr].acc : '0;
  assign out_sat    = out_valid && mem[rd_ptr].sat;
  assign grp_busy   = (cnt != '0);
  assign fifo_level = count;

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: vector table plus hand sequences
// for long groups, saturation, FIFO overflow/drain and reset.
module tb_mac_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [19:0] in_sum = '0;
  logic [7:0]  cfg_len = 8'd1;
  logic        clear = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_acc;
  logic        out_sat;
  logic        grp_busy;
  logic [2:0]  fifo_level;
  logic        err_drop;

  // Second instance built with a 20-bit accumulator for saturation checks.
  logic        v20 = 1'b0;
  logic [19:0] sum20 = '0;
  logic        out_valid20;
  logic [19:0] out_acc20;
  logic        out_sat20;
  logic        grp_busy20;
  logic [2:0]  fifo_level20;
  logic        err_drop20;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mac_result_collector dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
    .cfg_len(cfg_len), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat),
    .grp_busy(grp_busy), .fifo_level(fifo_level), .err_drop(err_drop)
  );

  mac_result_collector #(.ACC_W(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(v20), .in_sum(sum20),
    .cfg_len(8'd2), .clear(1'b0), .out_valid(out_valid20),
    .out_ready(1'b1), .out_acc(out_acc20), .out_sat(out_sat20),
    .grp_busy(grp_busy20), .fifo_level(fifo_level20), .err_drop(err_drop20)
  );

  typedef struct {
    logic        v;
    logic [19:0] sum;
    logic [7:0]  len;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [31:0] eacc;
    logic        esat;
    logic [2:0]  elvl;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [19:0] s, input logic [7:0] l,
                      input logic c, input logic r);
    in_valid  = v;
    in_sum    = s;
    cfg_len   = l;
    clear     = c;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_acc"},   out_acc, 0);
    check({tag, "_sat"},   out_sat, 0);
    check({tag, "_busy"},  grp_busy, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_err"},   err_drop, 0);
  endtask

  initial begin
    logic flag_ok;

    // len 1 pass-through
    vecs.push_back('{1, 5, 1, 0, 1, 1, 5, 0, 1, 0});
    vecs.push_back('{1, 7, 1, 0, 1, 1, 7, 0, 1, 0});
    vecs.push_back('{1, 9, 1, 0, 1, 1, 9, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 0, 1, 0, 0, 0, 0, 0});
    // len 4 with cfg_len changed mid-group, then len 2
    vecs.push_back('{1, 1, 4, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 2, 4, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 3, 2, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 4, 2, 0, 1, 1, 10, 0, 1, 0});
    vecs.push_back('{1, 6, 2, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 6, 2, 0, 1, 1, 12, 0, 1, 0});
    vecs.push_back('{0, 0, 2, 0, 1, 0, 0, 0, 0, 0});
    // clear beats a completing beat
    vecs.push_back('{1, 10, 3, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 20, 3, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 30, 3, 1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 3, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 3, 0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 3, 0, 1, 1, 3, 0, 1, 0});
    vecs.push_back('{0, 0, 3, 0, 1, 0, 0, 0, 0, 0});

    // Reset state
    #12;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, 0, 1);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].sum, vecs[i].len, vecs[i].clr, vecs[i].rdy);
      check($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      check($sformatf("vec%0d_acc", i),   out_acc,   vecs[i].eacc);
      check($sformatf("vec%0d_sat", i),   out_sat,   vecs[i].esat);
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].elvl);
      check($sformatf("vec%0d_busy", i),  grp_busy,  vecs[i].ebusy);
    end
    check("table_err", err_drop, 0);

    // cfg_len=0 means 256 beats per group
    flag_ok = 1'b1;
    for (int b = 1; b <= 256; b++) begin
      step(1, 20'd1040400, 8'd0, 0, 1);
      if (b < 256 && (grp_busy !== 1'b1 || out_valid !== 1'b0)) flag_ok = 1'b0;
    end
    check("len256_busy_during", flag_ok, 1);
    check("len256_valid", out_valid, 1);
    check("len256_acc", out_acc, 32'd266342400);
    check("len256_sat", out_sat, 0);
    check("len256_busy_end", grp_busy, 0);
    step(0, 0, 8'd0, 0, 1);
    check("len256_drained", fifo_level, 0);

    // Saturation on the 20-bit accumulator build
    v20 = 1'b1; sum20 = 20'd1040400;
    @(posedge clk); #1;
    check("sat20_busy", grp_busy20, 1);
    @(posedge clk); #1;
    check("sat20_valid", out_valid20, 1);
    check("sat20_acc", out_acc20, 20'hFFFFF);
    check("sat20_sat", out_sat20, 1);
    sum20 = 20'd3;
    @(posedge clk); #1;
    sum20 = 20'd4;
    @(posedge clk); #1;
    v20 = 1'b0;
    check("sat20_next_acc", out_acc20, 20'd7);
    check("sat20_next_sat", out_sat20, 0);

    // Overflow with the consumer stalled, then drain in order
    for (int k = 1; k <= 6; k++) begin
      step(1, 20'(k), 8'd1, 0, 0);
      if (k == 4) check("ovf_err_at_full", err_drop, 0);
      if (k == 5) check("ovf_err_set", err_drop, 1);
    end
    check("ovf_level", fifo_level, 4);
    check("ovf_err_sticky", err_drop, 1);
    check("ovf_hold_acc", out_acc, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("drain%0d_acc", k), out_acc, 32'(k));
      step(0, 0, 8'd1, 0, 1);
    end
    check("drain_level", fifo_level, 0);
    check("drain_valid", out_valid, 0);
    check("drain_err_kept", err_drop, 1);

    // Reset clears err_drop; full FIFO accepts push with simultaneous pop
    rst_n = 1'b0;
    #1;
    check("rst2_err", err_drop, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) step(1, 20'(k), 8'd1, 0, 0);
    step(1, 20'd5, 8'd1, 0, 1);
    check("fullpp_level", fifo_level, 4);
    check("fullpp_head", out_acc, 2);
    check("fullpp_err", err_drop, 0);

    // Reset mid-group with FIFO non-empty
    step(1, 20'd9, 8'd3, 0, 0);
    check("pre_rst_busy", grp_busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
